// File: rtl/hwpe_ctrl_package.sv
// rtl/hwpe_ctrl_package.sv - shared hwpe_ctrl types: uloop interface structs and sequencer states
package hwpe_ctrl_package;

    localparam int unsigned ULOOP_NB_LOOPS        = 4;
    localparam int unsigned ULOOP_SEQ_MAX_STREAMS = 8;

    typedef struct packed {
        logic enable;
        logic clear;
        logic ready;
    } ctrl_uloop_t;

    typedef struct packed {
        logic                                done;
        logic                                valid;
        logic [ULOOP_NB_LOOPS-1:0][15:0]     idx;
        logic [ULOOP_NB_LOOPS-1:0][31:0]     offs;
    } flags_uloop_t;

    typedef enum logic [2:0] {
        IDLE,
        ULCLR,
        STEP,
        WAIT_FL,
        LAUNCH,
        WAIT_ST,
        FINISH
    } uloop_seq_state_t;

endpackage

// File: rtl/hwpe_ctrl_seq_slot.sv
// rtl/hwpe_ctrl_seq_slot.sv - per-stream accept/finish sticky pair for the uloop sequencer
module hwpe_ctrl_seq_slot (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic mask_i,
    input  logic launch_i,
    input  logic track_i,
    input  logic ready_i,
    input  logic done_i,
    output logic start_o,
    output logic acc_o,
    output logic fin_o
);

    logic acc_q, acc_d;
    logic fin_q, fin_d;
    logic accept;

    assign start_o = launch_i & mask_i & ~acc_q;
    assign accept  = start_o & ready_i;

    // A done arriving together with its accept still counts as finished.
    always_comb begin
        acc_d = acc_q | accept;
        fin_d = fin_q | (track_i & done_i & (acc_q | accept));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= 1'b0;
            fin_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= 1'b0;
            fin_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            fin_q <= fin_d;
        end
    end

    assign acc_o = acc_q;
    assign fin_o = fin_q;

endmodule

// File: rtl/hwpe_ctrl_uloop_seq.sv
// rtl/hwpe_ctrl_uloop_seq.sv - steps the uloop, launches masked streamers, repeats until loop nest end
module hwpe_ctrl_uloop_seq
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned NB_STREAMS = 4,
    parameter int unsigned ITER_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [NB_STREAMS-1:0] strm_mask_i,
    output ctrl_uloop_t           uloop_ctrl_o,
    input  flags_uloop_t          uloop_flags_i,
    output flags_uloop_t          offs_o,
    output logic [NB_STREAMS-1:0] strm_start_o,
    input  logic [NB_STREAMS-1:0] strm_ready_i,
    input  logic [NB_STREAMS-1:0] strm_done_i,
    output logic [ITER_WIDTH-1:0] iter_o,
    output logic                  busy_o,
    output logic                  done_o
);

    uloop_seq_state_t        state_q, state_d;
    logic [NB_STREAMS-1:0]   mask_q, mask_d;
    logic                    last_q, last_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    flags_uloop_t            offs_q, offs_d;

    logic                    launch;
    logic                    track;
    logic                    slot_clr;
    logic [NB_STREAMS-1:0]   acc;
    logic [NB_STREAMS-1:0]   fin;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        last_d       = last_q;
        iter_d       = iter_q;
        offs_d       = offs_q;
        uloop_ctrl_o = '0;
        done_o       = 1'b0;
        launch       = 1'b0;
        track        = 1'b0;
        slot_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mask_d  = strm_mask_i;
                    iter_d  = '0;
                    state_d = ULCLR;
                end
            end
            ULCLR: begin
                uloop_ctrl_o.clear = 1'b1;
                state_d            = STEP;
            end
            STEP: begin
                uloop_ctrl_o.enable = 1'b1;
                uloop_ctrl_o.ready  = 1'b1;
                state_d             = WAIT_FL;
            end
            WAIT_FL: begin
                uloop_ctrl_o.enable = 1'b1;
                uloop_ctrl_o.ready  = 1'b1;
                if (uloop_flags_i.valid || uloop_flags_i.done) begin
                    offs_d  = uloop_flags_i;
                    last_d  = uloop_flags_i.done;
                    state_d = (mask_q == '0) ? WAIT_ST : LAUNCH;
                end
            end
            LAUNCH: begin
                launch = 1'b1;
                track  = 1'b1;
                if (acc == mask_q) begin
                    state_d = WAIT_ST;
                end
            end
            WAIT_ST: begin
                track = 1'b1;
                if (fin == mask_q) begin
                    iter_d   = iter_q + ITER_WIDTH'(1);
                    slot_clr = 1'b1;
                    state_d  = last_q ? FINISH : STEP;
                end
            end
            FINISH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            last_q  <= 1'b0;
            iter_q  <= '0;
            offs_q  <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            last_q  <= 1'b0;
            iter_q  <= '0;
            offs_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            iter_q  <= iter_d;
            offs_q  <= offs_d;
        end
    end

    // Slots are wiped both by an abort and at the end of every iteration.
    for (genvar i = 0; i < NB_STREAMS; i++) begin : g_slot
        hwpe_ctrl_seq_slot u_slot (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (clear_i | slot_clr),
            .mask_i   (mask_q[i]),
            .launch_i (launch),
            .track_i  (track),
            .ready_i  (strm_ready_i[i]),
            .done_i   (strm_done_i[i]),
            .start_o  (strm_start_o[i]),
            .acc_o    (acc[i]),
            .fin_o    (fin[i])
        );
    end

    assign offs_o = offs_q;
    assign iter_o = iter_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_hwpe_ctrl_uloop_seq.sv
// tb/tb_hwpe_ctrl_uloop_seq.sv - directed self-checking bench for hwpe_ctrl_uloop_seq
module tb_hwpe_ctrl_uloop_seq;
    import hwpe_ctrl_package::*;

    localparam int NS = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          start_i;
    logic [NS-1:0] strm_mask_i;
    ctrl_uloop_t   uloop_ctrl_o;
    flags_uloop_t  uloop_flags_i;
    flags_uloop_t  offs_o;
    logic [NS-1:0] strm_start_o;
    logic [NS-1:0] strm_ready_i;
    logic [NS-1:0] strm_done_i;
    logic [IW-1:0] iter_o;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;

    // model configuration (written by the test tasks only)
    int ul_total;
    int rdy_dly   [NS];
    int done_dly  [NS];
    bit done_same [NS];

    // model/monitor state (written by the model process only)
    int  cyc = 0;
    int  ul_n, en_cnt;
    int  rcnt [NS];
    int  dcnt [NS];
    bit  pend [NS];
    bit  en_prev;
    int  step_cnt = 0, done_cnt = 0, start1_cnt = 0, launch_cnt = 0;
    int  acc1_at = 0, wst_at = 0;
    uloop_seq_state_t prev_st;

    always #5 clk = ~clk;

    hwpe_ctrl_uloop_seq #(.NB_STREAMS(NS), .ITER_WIDTH(IW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .strm_mask_i   (strm_mask_i),
        .uloop_ctrl_o  (uloop_ctrl_o),
        .uloop_flags_i (uloop_flags_i),
        .offs_o        (offs_o),
        .strm_start_o  (strm_start_o),
        .strm_ready_i  (strm_ready_i),
        .strm_done_i   (strm_done_i),
        .iter_o        (iter_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    function automatic flags_uloop_t mk_flags(input int n, input bit last);
        flags_uloop_t f;
        f = '0;
        for (int i = 0; i < ULOOP_NB_LOOPS; i++) begin
            f.offs[i] = 32'(n * 256 + i * 4);
            f.idx[i]  = 16'(n + i);
        end
        f.valid = 1'b1;
        f.done  = last;
        return f;
    endfunction

    // uloop + streamer behavioural models, plus event monitors
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (uloop_ctrl_o.enable && !en_prev) step_cnt = step_cnt + 1;
        en_prev = uloop_ctrl_o.enable;
        if (done_o) done_cnt = done_cnt + 1;
        if (strm_start_o[1]) start1_cnt = start1_cnt + 1;
        if (dut.state_q == LAUNCH) launch_cnt = launch_cnt + 1;
        if (dut.state_q == WAIT_ST && prev_st != WAIT_ST) wst_at = cyc;
        prev_st = dut.state_q;

        if (rst_i || clear_i) begin
            ul_n          = 0;
            en_cnt        = 0;
            uloop_flags_i = '0;
            strm_ready_i  = '0;
            strm_done_i   = '0;
            for (int i = 0; i < NS; i++) begin
                rcnt[i] = 0;
                dcnt[i] = 0;
                pend[i] = 1'b0;
            end
        end else begin
            if (uloop_ctrl_o.clear) begin
                ul_n          = 0;
                en_cnt        = 0;
                uloop_flags_i = '0;
            end else if (uloop_ctrl_o.enable) begin
                en_cnt = en_cnt + 1;
                if (en_cnt == 2) begin
                    ul_n          = ul_n + 1;
                    uloop_flags_i = mk_flags(ul_n, ul_n >= ul_total);
                end else begin
                    uloop_flags_i = '0;
                end
            end else begin
                en_cnt        = 0;
                uloop_flags_i = '0;
            end

            for (int i = 0; i < NS; i++) begin
                strm_ready_i[i] = 1'b0;
                strm_done_i[i]  = 1'b0;
                if (strm_start_o[i]) begin
                    if (rcnt[i] >= rdy_dly[i]) begin
                        strm_ready_i[i] = 1'b1;
                        rcnt[i]         = 0;
                        dcnt[i]         = 0;
                        if (done_same[i]) strm_done_i[i] = 1'b1;
                        else              pend[i] = 1'b1;
                        if (i == 1) acc1_at = cyc;
                    end else begin
                        rcnt[i] = rcnt[i] + 1;
                    end
                end else if (pend[i]) begin
                    if (dcnt[i] >= done_dly[i]) begin
                        strm_done_i[i] = 1'b1;
                        pend[i]        = 1'b0;
                    end else begin
                        dcnt[i] = dcnt[i] + 1;
                    end
                end else begin
                    rcnt[i] = 0;
                end
            end
        end
    end

    task automatic set_cfg(input int total, input int rd, input int dd, input bit same);
        ul_total = total;
        for (int i = 0; i < NS; i++) begin
            rdy_dly[i]   = rd;
            done_dly[i]  = dd;
            done_same[i] = same;
        end
    endtask

    task automatic pulse_start(input logic [NS-1:0] mask);
        @(negedge clk);
        strm_mask_i = mask;
        start_i     = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // counts negedges until done_o is seen; returns bound+1 on timeout
    task automatic wait_done(input int bound, output int k);
        k = 0;
        while (k <= bound) begin
            @(negedge clk);
            k = k + 1;
            if (done_o === 1'b1) break;
        end
    endtask

    task automatic wait_state(input uloop_seq_state_t st, input int bound, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (dut.state_q == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; strm_mask_i = '0;
        set_cfg(1, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || strm_start_o !== '0)
            begin failures++; $display("FAIL reset_ctl busy=%b done=%b start=%b required 0", busy_o, done_o, strm_start_o); end
        checks++;
        if (uloop_ctrl_o !== 3'b000 || iter_o !== '0)
            begin failures++; $display("FAIL reset_ul ctrl=%b iter=%0d required 0", uloop_ctrl_o, iter_o); end
        checks++;
        if (offs_o !== '0)
            begin failures++; $display("FAIL reset_offs offs=%h required 0", offs_o); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int s0, d0, k;
        set_cfg(3, 0, 1, 1'b0);
        rdy_dly[1]  = 2;
        done_dly[1] = 3;
        s0 = step_cnt; d0 = done_cnt;
        pulse_start(4'b0011);
        @(negedge clk);
        checks++;
        if (uloop_ctrl_o !== 3'b010)
            begin failures++; $display("FAIL basic_ulclr ctrl=%b required 010", uloop_ctrl_o); end
        @(negedge clk);
        checks++;
        if (uloop_ctrl_o !== 3'b101)
            begin failures++; $display("FAIL basic_step ctrl=%b required 101", uloop_ctrl_o); end
        wait_done(200, k);
        checks++;
        if (k > 200) begin failures++; $display("FAIL basic_timeout k=%0d required <=200", k); end
        checks++;
        if (iter_o !== 16'd3) begin failures++; $display("FAIL basic_iter iter=%0d required 3", iter_o); end
        checks++;
        if (offs_o !== mk_flags(3, 1'b1))
            begin failures++; $display("FAIL basic_offs offs=%h required %h", offs_o, mk_flags(3, 1'b1)); end
        @(negedge clk);
        checks++;
        if (step_cnt - s0 != 3) begin failures++; $display("FAIL basic_steps steps=%0d required 3", step_cnt - s0); end
        checks++;
        if (done_cnt - d0 != 1 || busy_o !== 1'b0)
            begin failures++; $display("FAIL basic_done pulses=%0d busy=%b required 1 0", done_cnt - d0, busy_o); end
    endtask

    task automatic test_stagger;
        int s1, t0, k;
        set_cfg(1, 0, 0, 1'b0);
        rdy_dly[1] = 5;
        s1 = start1_cnt; t0 = cyc;
        pulse_start(4'b0011);
        wait_done(100, k);
        checks++;
        if (k != 12) begin failures++; $display("FAIL stagger_latency k=%0d required 12", k); end
        checks++;
        if (start1_cnt - s1 != 6)
            begin failures++; $display("FAIL stagger_hold cycles=%0d required 6", start1_cnt - s1); end
        checks++;
        if (acc1_at <= t0 || wst_at - acc1_at != 2)
            begin failures++; $display("FAIL stagger_wst acc1=%0d wst=%0d required wst=acc1+2", acc1_at, wst_at); end
        checks++;
        if (iter_o !== 16'd1) begin failures++; $display("FAIL stagger_iter iter=%0d required 1", iter_o); end
        @(negedge clk);
    endtask

    task automatic test_same_cycle;
        int k;
        set_cfg(1, 0, 0, 1'b1);
        pulse_start(4'b0100);
        wait_done(50, k);
        checks++;
        if (k != 7) begin failures++; $display("FAIL same_latency k=%0d required 7", k); end
        checks++;
        if (iter_o !== 16'd1) begin failures++; $display("FAIL same_iter iter=%0d required 1", iter_o); end
        @(negedge clk);
    endtask

    task automatic test_mask_zero;
        int l0, d0, k;
        set_cfg(1, 0, 0, 1'b0);
        l0 = launch_cnt; d0 = done_cnt;
        pulse_start(4'b0000);
        wait_done(50, k);
        checks++;
        if (k != 5) begin failures++; $display("FAIL zero_latency k=%0d required 5", k); end
        checks++;
        if (iter_o !== 16'd1) begin failures++; $display("FAIL zero_iter iter=%0d required 1", iter_o); end
        @(negedge clk);
        checks++;
        if (launch_cnt != l0 || done_cnt - d0 != 1)
            begin failures++; $display("FAIL zero_launch launches=%0d dones=%0d required 0 1", launch_cnt - l0, done_cnt - d0); end
    endtask

    task automatic test_start_busy;
        int d0, k;
        bit ok;
        set_cfg(2, 0, 1, 1'b0);
        d0 = done_cnt;
        pulse_start(4'b0001);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (dut.state_q == WAIT_FL && iter_o == 16'd1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL busy_reach_wait_fl found=0 required 1"); end
        strm_mask_i = 4'b1111;
        start_i     = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        checks++;
        if (iter_o !== 16'd1 || busy_o !== 1'b1)
            begin failures++; $display("FAIL busy_ignored iter=%0d busy=%b required 1 1", iter_o, busy_o); end
        wait_done(100, k);
        checks++;
        if (k > 100 || iter_o !== 16'd2)
            begin failures++; $display("FAIL busy_complete k=%0d iter=%0d required <=100 2", k, iter_o); end
        checks++;
        if (offs_o !== mk_flags(2, 1'b1))
            begin failures++; $display("FAIL busy_offs offs=%h required %h", offs_o, mk_flags(2, 1'b1)); end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("FAIL busy_done pulses=%0d required 1", done_cnt - d0); end
    endtask

    task automatic test_rst_mid;
        bit ok;
        set_cfg(1, 0, 30, 1'b0);
        pulse_start(4'b0001);
        wait_state(WAIT_ST, 40, ok);
        checks++;
        if (!ok || offs_o === '0)
            begin failures++; $display("FAIL rst_reach_wait_st found=%b offs=%h required 1 nonzero", ok, offs_o); end
        rst_i = 1'b1;
        #1;
        checks++;
        if (dut.state_q !== IDLE || busy_o !== 1'b0)
            begin failures++; $display("FAIL rst_mid_state state=%0d busy=%b required IDLE 0", dut.state_q, busy_o); end
        checks++;
        if (offs_o !== '0 || iter_o !== '0 || done_o !== 1'b0)
            begin failures++; $display("FAIL rst_mid_regs offs=%h iter=%0d done=%b required 0", offs_o, iter_o, done_o); end
        checks++;
        if (uloop_ctrl_o !== 3'b000 || strm_start_o !== '0)
            begin failures++; $display("FAIL rst_mid_ctl ctrl=%b start=%b required 0", uloop_ctrl_o, strm_start_o); end
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_launch;
        bit ok;
        int k;
        set_cfg(1, 10, 0, 1'b0);
        pulse_start(4'b0001);
        wait_state(LAUNCH, 40, ok);
        checks++;
        if (!ok || strm_start_o !== 4'b0001)
            begin failures++; $display("FAIL clr_reach_launch found=%b start=%b required 1 0001", ok, strm_start_o); end
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (strm_start_o !== '0 || busy_o !== 1'b0)
            begin failures++; $display("FAIL clr_launch start=%b busy=%b required 0 0", strm_start_o, busy_o); end
        @(negedge clk);
        clear_i = 1'b0;
        set_cfg(1, 0, 0, 1'b0);
        pulse_start(4'b0001);
        wait_done(50, k);
        checks++;
        if (k > 50 || iter_o !== 16'd1)
            begin failures++; $display("FAIL clr_rerun k=%0d iter=%0d required <=50 1", k, iter_o); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stagger();
        test_same_cycle();
        test_mask_zero();
        test_start_busy();
        test_rst_mid();
        test_clear_launch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish", $time);
        $fatal(1);
    end

endmodule
